// File: rtl/pipe_track.sv
// Pipeline record tracker: carries {instr, A3, Tnew, WD} through the E, M and W stages.
// Optional stall counter on bubble_cnt, enabled by defining PERF_CNT_EN.
module pipe_track (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_instr,
    input  logic [4:0]  D_A3,
    input  logic [1:0]  D_Tnew,
    input  logic [31:0] D_WD,
    input  logic        stall,
    input  logic [31:0] E_aluout,
    input  logic [31:0] M_dmrd,
    output logic [31:0] E_instr,
    output logic [31:0] M_instr,
    output logic [31:0] W_instr,
    output logic [4:0]  E_A3,
    output logic [4:0]  M_A3,
    output logic [4:0]  W_A3,
    output logic [1:0]  E_Tnew,
    output logic [1:0]  M_Tnew,
    output logic [1:0]  W_Tnew,
    output logic [31:0] E_WD,
    output logic [31:0] M_WD,
    output logic [31:0] W_WD,
    output logic        W_we
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned A3_W    = 5;
    localparam int unsigned TNEW_W  = 2;
    localparam int unsigned WD_W    = 32;
    localparam int unsigned CNT_W   = 32;

    // Remaining-cycle countdown; saturates at zero instead of wrapping.
    function automatic logic [TNEW_W-1:0] dec_tnew(input logic [TNEW_W-1:0] t);
        return (t == TNEW_W'(0)) ? TNEW_W'(0) : TNEW_W'(t - TNEW_W'(1));
    endfunction

    logic [INSTR_W-1:0] e_instr_next;
    logic [A3_W-1:0]    e_a3_next;
    logic [TNEW_W-1:0]  e_tnew_next;
    logic [WD_W-1:0]    e_wd_next;

    logic [INSTR_W-1:0] m_instr_next;
    logic [A3_W-1:0]    m_a3_next;
    logic [TNEW_W-1:0]  m_tnew_next;
    logic [WD_W-1:0]    m_wd_next;

    logic [INSTR_W-1:0] w_instr_next;
    logic [A3_W-1:0]    w_a3_next;
    logic [TNEW_W-1:0]  w_tnew_next;
    logic [WD_W-1:0]    w_wd_next;

    // E load: bubble on stall; a record without a destination carries no result.
    always_comb begin
        e_instr_next = '0;
        e_a3_next    = '0;
        e_tnew_next  = '0;
        e_wd_next    = '0;
        if (!stall) begin
            e_instr_next = D_instr;
            e_a3_next    = D_A3;
            if (D_A3 != A3_W'(0)) begin
                e_tnew_next = D_Tnew;
                e_wd_next   = D_WD;
            end
        end
    end

    // M and W loads capture the stage result on the cycle it becomes available.
    always_comb begin
        m_instr_next = E_instr;
        m_a3_next    = E_A3;
        m_tnew_next  = dec_tnew(E_Tnew);
        m_wd_next    = (E_Tnew == TNEW_W'(1)) ? E_aluout : E_WD;

        w_instr_next = M_instr;
        w_a3_next    = M_A3;
        w_tnew_next  = dec_tnew(M_Tnew);
        w_wd_next    = (M_Tnew == TNEW_W'(1)) ? M_dmrd : M_WD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            E_instr <= '0;
            E_A3    <= '0;
            E_Tnew  <= '0;
            E_WD    <= '0;
            M_instr <= '0;
            M_A3    <= '0;
            M_Tnew  <= '0;
            M_WD    <= '0;
            W_instr <= '0;
            W_A3    <= '0;
            W_Tnew  <= '0;
            W_WD    <= '0;
        end else begin
            E_instr <= e_instr_next;
            E_A3    <= e_a3_next;
            E_Tnew  <= e_tnew_next;
            E_WD    <= e_wd_next;
            M_instr <= m_instr_next;
            M_A3    <= m_a3_next;
            M_Tnew  <= m_tnew_next;
            M_WD    <= m_wd_next;
            W_instr <= w_instr_next;
            W_A3    <= w_a3_next;
            W_Tnew  <= w_tnew_next;
            W_WD    <= w_wd_next;
        end
    end

    assign W_we = (W_A3 != A3_W'(0));

`ifdef PERF_CNT_EN
    // Counts stall edges, holding at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (stall && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_track.sv
// Scoreboard bench for pipe_track: stimulus queues expected values tagged with a clock edge,
// a negedge monitor compares them. Define PERF_CNT_EN to also cover bubble_cnt.
module tb_pipe_track;

    localparam int S_E_INSTR = 0;
    localparam int S_E_A3    = 1;
    localparam int S_E_TNEW  = 2;
    localparam int S_E_WD    = 3;
    localparam int S_M_INSTR = 4;
    localparam int S_M_A3    = 5;
    localparam int S_M_TNEW  = 6;
    localparam int S_M_WD    = 7;
    localparam int S_W_INSTR = 8;
    localparam int S_W_A3    = 9;
    localparam int S_W_TNEW  = 10;
    localparam int S_W_WD    = 11;
    localparam int S_W_WE    = 12;
    localparam int S_BUBBLE  = 13;

    logic        clk;
    logic        reset;
    logic [31:0] D_instr;
    logic [4:0]  D_A3;
    logic [1:0]  D_Tnew;
    logic [31:0] D_WD;
    logic        stall;
    logic [31:0] E_aluout;
    logic [31:0] M_dmrd;
    logic [31:0] E_instr, M_instr, W_instr;
    logic [4:0]  E_A3, M_A3, W_A3;
    logic [1:0]  E_Tnew, M_Tnew, W_Tnew;
    logic [31:0] E_WD, M_WD, W_WD;
    logic        W_we;
    logic [31:0] bubble_cnt;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } chk_t;

    chk_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] act;
    string       names[14] = '{"E_instr", "E_A3", "E_Tnew", "E_WD", "M_instr", "M_A3", "M_Tnew",
                               "M_WD", "W_instr", "W_A3", "W_Tnew", "W_WD", "W_we", "bubble_cnt"};

    pipe_track dut (
        .clk(clk), .reset(reset),
        .D_instr(D_instr), .D_A3(D_A3), .D_Tnew(D_Tnew), .D_WD(D_WD),
        .stall(stall), .E_aluout(E_aluout), .M_dmrd(M_dmrd),
        .E_instr(E_instr), .M_instr(M_instr), .W_instr(W_instr),
        .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
        .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .W_Tnew(W_Tnew),
        .E_WD(E_WD), .M_WD(M_WD), .W_WD(W_WD),
        .W_we(W_we)
`ifdef PERF_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

`ifndef PERF_CNT_EN
    assign bubble_cnt = 32'd0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_act(input int s);
        case (s)
            S_E_INSTR: return E_instr;
            S_E_A3:    return 32'(E_A3);
            S_E_TNEW:  return 32'(E_Tnew);
            S_E_WD:    return E_WD;
            S_M_INSTR: return M_instr;
            S_M_A3:    return 32'(M_A3);
            S_M_TNEW:  return 32'(M_Tnew);
            S_M_WD:    return M_WD;
            S_W_INSTR: return W_instr;
            S_W_A3:    return 32'(W_A3);
            S_W_TNEW:  return 32'(W_Tnew);
            S_W_WD:    return W_WD;
            S_W_WE:    return 32'(W_we);
            default:   return bubble_cnt;
        endcase
    endfunction

    // Monitor: every item due at this edge count is compared and retired.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                n_cmp = n_cmp + 1;
                act = get_act(q[i].sig);
                if (act !== q[i].val) begin
                    n_err = n_err + 1;
                    $display("FAIL %s edge=%0d got=%h want=%h", names[q[i].sig], cyc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    // d = number of edges from now until the value must be visible.
    task automatic expect_at(input int d, input int s, input logic [31:0] v);
        chk_t c;
        c.cyc = cyc + d;
        c.sig = s;
        c.val = v;
        q.push_back(c);
    endtask

    task automatic expect_all_zero();
        for (int s = 0; s <= S_W_WE; s++) expect_at(0, s, 32'd0);
`ifdef PERF_CNT_EN
        expect_at(0, S_BUBBLE, 32'd0);
`endif
    endtask

    task automatic drive_d(input logic [31:0] i, input logic [4:0] a3, input logic [1:0] t,
                           input logic [31:0] wd);
        D_instr = i;
        D_A3    = a3;
        D_Tnew  = t;
        D_WD    = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        E_aluout = 32'd0;
        M_dmrd = 32'd0;
        drive_d(32'h0, 5'd0, 2'd0, 32'h0);
        #1 reset = 1'b1;
        tick();
        expect_all_zero();
        @(negedge clk);
        #1 reset = 1'b0;

        // S1: ALU op enters
        drive_d(32'h00851020, 5'd2, 2'd1, 32'hDEAD0000);
        expect_at(1, S_E_INSTR, 32'h00851020);
        expect_at(1, S_E_A3, 32'd2);
        expect_at(1, S_E_TNEW, 32'd1);
        expect_at(2, S_M_WD, 32'h1234);
        expect_at(2, S_M_TNEW, 32'd0);
        expect_at(3, S_W_INSTR, 32'h00851020);
        expect_at(3, S_W_WD, 32'h1234);
        expect_at(3, S_W_TNEW, 32'd0);
        expect_at(3, S_W_WE, 32'd1);
        tick();
        // S2: ALU in E, load enters
        E_aluout = 32'h1234;
        drive_d(32'h8D280000, 5'd8, 2'd2, 32'h0);
        expect_at(1, S_E_TNEW, 32'd2);
        expect_at(2, S_M_TNEW, 32'd1);
        expect_at(3, S_W_TNEW, 32'd0);
        expect_at(3, S_W_A3, 32'd8);
        expect_at(3, S_W_WD, 32'hCAFEBABE);
        tick();
        // S3: link enters; ALU in M must ignore M_dmrd
        E_aluout = 32'h9999;
        M_dmrd = 32'h1111;
        drive_d(32'h0C000C04, 5'd31, 2'd0, 32'h00003010);
        expect_at(1, S_E_WD, 32'h00003010);
        expect_at(1, S_E_TNEW, 32'd0);
        expect_at(2, S_M_WD, 32'h00003010);
        expect_at(3, S_W_WD, 32'h00003010);
        expect_at(3, S_W_WE, 32'd1);
        tick();
        // S4: load in M gets its data; zero-destination record enters
        M_dmrd = 32'hCAFEBABE;
        E_aluout = 32'hBAD0BAD0;
        drive_d(32'h00001025, 5'd0, 2'd2, 32'h55);
        expect_at(1, S_E_TNEW, 32'd0);
        expect_at(1, S_E_WD, 32'd0);
        expect_at(1, S_E_INSTR, 32'h00001025);
        expect_at(3, S_W_WE, 32'd0);
        expect_at(3, S_W_WD, 32'd0);
        tick();
        // S5: Tnew=3 record enters
        M_dmrd = 32'h77777777;
        E_aluout = 32'h66;
        drive_d(32'h3C050001, 5'd5, 2'd3, 32'h0);
        expect_at(2, S_M_TNEW, 32'd2);
        expect_at(3, S_W_TNEW, 32'd1);
        tick();
        // S6: load that will be stalled behind
        M_dmrd = 32'h88;
        E_aluout = 32'h99;
        drive_d(32'h8D290004, 5'd9, 2'd2, 32'h0);
        expect_at(1, S_E_INSTR, 32'h8D290004);
        expect_at(1, S_E_TNEW, 32'd2);
        tick();
        // S7: first stall cycle
        stall = 1'b1;
        E_aluout = 32'h5A5A5A5A;
        M_dmrd = 32'h33;
        drive_d(32'hFFFFFFFF, 5'd7, 2'd1, 32'hABCD);
        expect_at(1, S_E_INSTR, 32'd0);
        expect_at(1, S_E_A3, 32'd0);
        expect_at(1, S_E_TNEW, 32'd0);
        expect_at(1, S_E_WD, 32'd0);
        expect_at(1, S_M_INSTR, 32'h8D290004);
        expect_at(1, S_M_TNEW, 32'd1);
        expect_at(1, S_M_WD, 32'd0);
        tick();
        // S8: second stall cycle while the load captures memory data
        M_dmrd = 32'h12345678;
        expect_at(1, S_E_INSTR, 32'd0);
        expect_at(1, S_E_TNEW, 32'd0);
        expect_at(1, S_W_INSTR, 32'h8D290004);
        expect_at(1, S_W_A3, 32'd9);
        expect_at(1, S_W_TNEW, 32'd0);
        expect_at(1, S_W_WD, 32'h12345678);
`ifdef PERF_CNT_EN
        expect_at(1, S_BUBBLE, 32'd2);
`endif
        tick();
        // Refill, then reset mid-pipeline between edges
        stall = 1'b0;
        drive_d(32'hAAAA0000, 5'd3, 2'd0, 32'h42);
        tick();
        drive_d(32'hBBBB0000, 5'd4, 2'd1, 32'h0);
        tick();
        reset = 1'b1;
        expect_all_zero();
        drive_d(32'h12340000, 5'd6, 2'd1, 32'h0);
        #1;
        if (E_instr !== 32'd0) begin
            n_err = n_err + 1;
            $display("FAIL async reset E_instr got=%h", E_instr);
        end
        if (M_instr !== 32'd0) begin
            n_err = n_err + 1;
            $display("FAIL async reset M_instr got=%h", M_instr);
        end
        if (W_instr !== 32'd0) begin
            n_err = n_err + 1;
            $display("FAIL async reset W_instr got=%h", W_instr);
        end
        if (E_WD !== 32'd0) begin
            n_err = n_err + 1;
            $display("FAIL async reset E_WD got=%h", E_WD);
        end
        if (M_Tnew !== 2'd0) begin
            n_err = n_err + 1;
            $display("FAIL async reset M_Tnew got=%h", M_Tnew);
        end
        if (W_WD !== 32'd0) begin
            n_err = n_err + 1;
            $display("FAIL async reset W_WD got=%h", W_WD);
        end
        if (W_we !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL async reset W_we got=%b", W_we);
        end
        @(negedge clk);
        #1 reset = 1'b0;
        expect_at(1, S_E_INSTR, 32'h12340000);
        expect_at(1, S_E_A3, 32'd6);
        expect_at(1, S_E_TNEW, 32'd1);
        expect_at(1, S_M_INSTR, 32'd0);
        expect_at(1, S_W_INSTR, 32'd0);
        tick();
        E_aluout = 32'h0BADF00D;
        drive_d(32'h0, 5'd0, 2'd0, 32'h0);
        expect_at(1, S_M_WD, 32'h0BADF00D);
        expect_at(2, S_W_WD, 32'h0BADF00D);
        expect_at(2, S_W_WE, 32'd1);
        for (int k = 0; k < 4; k++) tick();

        if (W_instr !== 32'd0) begin
            n_err = n_err + 1;
            $display("FAIL drained W_instr got=%h", W_instr);
        end
        if (W_A3 !== 5'd0) begin
            n_err = n_err + 1;
            $display("FAIL drained W_A3 got=%h", W_A3);
        end
        if (W_we !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL drained W_we got=%b", W_we);
        end
        if (n_cmp < 12) begin
            n_err = n_err + 1;
            $display("FAIL monitor compared only %0d items", n_cmp);
        end

        // Any item the monitor never reached is a failure.
        while (q.size() > 0) begin
            n_err = n_err + 1;
            $display("FAIL %s never checked (due edge %0d, want=%h)", names[q[0].sig], q[0].cyc, q[0].val);
            q.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_track.md
PIPE_TRACK -- requirements
Module: pipe_track

Interface
REQ-001 The module SHALL have the following ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- D_instr  input  32  instruction leaving D stage.
- D_A3  input  5  destination register of D_instr (0 = no write).
- D_Tnew  input  2  cycles from entering E until the result exists.
- D_WD  input  32  result already known in D (link value PC+8); otherwise don't-care.
- stall  input  1  hazard stall; inserts a bubble into E.
- E_aluout  input  32  ALU result computed in E this cycle.
- M_dmrd  input  32  data-memory read data in M this cycle.
- E_instr, M_instr, W_instr  output  32 each  stage instructions.
- E_A3, M_A3, W_A3  output  5 each  stage destination registers.
- E_Tnew, M_Tnew, W_Tnew  output  2 each  remaining cycles until stage result is valid.
- E_WD, M_WD, W_WD  output  32 each  stage result; valid only when the matching Tnew = 0.
- W_we  output  1  GRF write enable, (W_A3 != 0).
- bubble_cnt  output  32  present only with PERF_CNT_EN.

Function
REQ-002 The module SHALL hold three stage records (E, M, W), each consisting of {instr, A3, Tnew, WD} and all registered.
REQ-003 Every rising clk edge SHALL advance all records: D->E, E->M, M->W; old W is discarded.
REQ-004 Tnew on advance SHALL be dec(t) = (t == 0) ? 0 : t-1, saturating at 0 with no wrap to 3.
REQ-005 E load when stall = 0 SHALL be: instr = D_instr, A3 = D_A3, Tnew = D_Tnew, WD = D_WD.
REQ-006 E load when stall = 1 SHALL be a bubble {0, 0, 0, 0}, while M and W still advance the same cycle.
REQ-007 If D_A3 = 0, the E load SHALL force Tnew = 0 and WD = 0 regardless of D_Tnew and D_WD.
REQ-008 M load SHALL be: instr = E_instr, A3 = E_A3, Tnew = dec(E_Tnew), WD = (E_Tnew == 1) ? E_aluout : E_WD.
REQ-009 W load SHALL be: instr = M_instr, A3 = M_A3, Tnew = dec(M_Tnew), WD = (M_Tnew == 1) ? M_dmrd : M_WD.
REQ-010 A record entering with Tnew = 0 SHALL keep its WD unchanged in every later stage.
REQ-011 A D_Tnew of 3 SHALL reach W with Tnew = 1; the block does not flag this, and it is the decoder's duty to never issue it.
REQ-012 All outputs except bubble_cnt SHALL come directly from the record registers, with no combinational path from any input to any output.
REQ-013 W_we SHALL be a combinational decode of the W_A3 register only.
REQ-014 When a stall and a result capture occur in the same cycle, both SHALL take effect independently.
REQ-015 Latency SHALL be 1 cycle per stage: D_instr appears on W_instr 3 edges after capture if no stall occurred on the capture edge.

Reset
REQ-016 On reset assertion, all record fields SHALL go to 0 immediately, without waiting for clk.
REQ-017 With all records at 0 after reset, E_instr, M_instr, W_instr, all A3, all Tnew, all WD and W_we SHALL read 0.
REQ-018 bubble_cnt SHALL reset to 0.
REQ-019 A reset asserted mid-pipeline SHALL discard all in-flight records.
REQ-020 The first edge after reset release SHALL load E per REQ-005/006.

Configuration
REQ-021 With macro PERF_CNT_EN defined, bubble_cnt SHALL exist and increment by 1 on each edge where stall = 1, saturating at 32'hFFFFFFFF.
REQ-022 Without PERF_CNT_EN, the bubble_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Reset test: assert reset between edges -> all outputs read 0 before the next clk edge.
REQ-024 ALU flow: D_instr = 0x00851020, D_A3 = 2, D_Tnew = 1, E_aluout = 0x1234 at the E edge -> M_WD = 0x1234 with M_Tnew = 0, then W_WD = 0x1234 with W_we = 1.
REQ-025 Load flow: D_A3 = 8, D_Tnew = 2, M_dmrd = 0xCAFEBABE while in M -> E_Tnew = 2, M_Tnew = 1, W_Tnew = 0, W_WD = 0xCAFEBABE.
REQ-026 Link flow: D_A3 = 31, D_Tnew = 0, D_WD = 0x00003010 -> E_WD = M_WD = W_WD = 0x00003010 in successive cycles, ignoring E_aluout and M_dmrd.
REQ-027 Stall: stall = 1 for 2 cycles with a load in E -> E holds zeros for 2 cycles, the load proceeds to M then W, and bubble_cnt = 2 with PERF_CNT_EN.
REQ-028 Zero-destination: D_A3 = 0, D_Tnew = 2, D_WD = 0x55 -> E_Tnew = 0, E_WD = 0, and W_we = 0 when the record reaches W.
